uart_rx_shifter: RTL and testbench

UART_RX_SHIFTER -- requirements
Module: uart_rx_shifter

---
 rtl/uart_pkg.sv | 20 ++
 rtl/uart_baud_tick.sv | 28 ++
 rtl/uart_rx_shifter.sv | 154 +++++++++++++++
 tb/tb_uart_rx_shifter.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the 16x-oversampling UART receiver.
// UART_RX_PARITY_EN adds the even-parity state to the FSM encoding.
package uart_pkg;

  localparam int OVERSAMPLE = 16;
  localparam int MID_TICK   = 8;
  localparam int DATA_BITS  = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
`ifdef UART_RX_PARITY_EN
    ST_PARITY,
`endif
    ST_STOP,
    ST_WAIT_HIGH
  } state_t;

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: counts 0..CLK_DIV-1 and pulses tick on the wrap.
// restart realigns the count to zero so bit timing starts at the start edge.
module uart_baud_tick #(
  parameter int CLK_DIV = 27
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic tick
);

  localparam logic [15:0] LAST = 16'(CLK_DIV - 1);

  logic [15:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt <= '0;
    end else if (restart || cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 16'd1;
    end
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/uart_rx_shifter.sv
// 8N1 UART receiver with 16x oversampling and a 2-flop input synchronizer.
// Define UART_RX_PARITY_EN for an even-parity bit and the parity_err output.
module uart_rx_shifter #(
  parameter int CLK_DIV   = 27,
  parameter int DATA_BITS = uart_pkg::DATA_BITS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  input  logic                 rx_en,
  output logic [DATA_BITS-1:0] data_in,
  output logic                 stop_valid,
  output logic                 framing_err,
  output logic                 busy
`ifdef UART_RX_PARITY_EN
  ,
  output logic                 parity_err
`endif
);

  import uart_pkg::*;

  // Handshake: stop_valid is a one-cycle strobe with no ready; data_in is
  // valid in that cycle and holds until the next good frame completes.

  state_t               state;
  logic                 rx_s1, rx_s2, rx_prev;
  logic                 fall, restart, tick;
  logic [3:0]           os_cnt;
  logic [2:0]           bit_cnt;
  logic [DATA_BITS-1:0] shift;
`ifdef UART_RX_PARITY_EN
  logic                 parity_bad;
`endif

  assign fall    = rx_prev & ~rx_s2;
  assign restart = (state == ST_IDLE) && rx_en && fall;
  assign busy    = (state != ST_IDLE);

  uart_baud_tick #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk     (clk),
    .rst     (rst),
    .restart (restart),
    .tick    (tick)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= ST_IDLE;
      rx_s1       <= 1'b1;
      rx_s2       <= 1'b1;
      rx_prev     <= 1'b1;
      os_cnt      <= '0;
      bit_cnt     <= '0;
      shift       <= '0;
      data_in     <= '0;
      stop_valid  <= 1'b0;
      framing_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_bad  <= 1'b0;
      parity_err  <= 1'b0;
`endif
    end else begin
      rx_s1       <= rx;
      rx_s2       <= rx_s1;
      rx_prev     <= rx_s2;
      stop_valid  <= 1'b0;
      framing_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err  <= 1'b0;
`endif
      if (!rx_en) begin
        state <= ST_IDLE;
      end else begin
        case (state)
          ST_IDLE: begin
            if (fall) begin
              state  <= ST_START;
              os_cnt <= '0;
            end
          end
          ST_START: begin
            if (tick) begin
              if (os_cnt == 4'(MID_TICK - 1)) begin
                os_cnt  <= '0;
                bit_cnt <= '0;
                state   <= rx_s2 ? ST_IDLE : ST_DATA;
              end else begin
                os_cnt <= os_cnt + 4'd1;
              end
            end
          end
          ST_DATA: begin
            if (tick) begin
              if (os_cnt == 4'(OVERSAMPLE - 1)) begin
                os_cnt  <= '0;
                shift   <= {rx_s2, shift[DATA_BITS-1:1]};
                bit_cnt <= bit_cnt + 3'd1;
                if (bit_cnt == 3'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
                  state <= ST_PARITY;
`else
                  state <= ST_STOP;
`endif
                end
              end else begin
                os_cnt <= os_cnt + 4'd1;
              end
            end
          end
`ifdef UART_RX_PARITY_EN
          ST_PARITY: begin
            if (tick) begin
              if (os_cnt == 4'(OVERSAMPLE - 1)) begin
                os_cnt     <= '0;
                parity_bad <= ^{shift, rx_s2};
                state      <= ST_STOP;
              end else begin
                os_cnt <= os_cnt + 4'd1;
              end
            end
          end
`endif
          ST_STOP: begin
            if (tick) begin
              if (os_cnt == 4'(OVERSAMPLE - 1)) begin
                os_cnt <= '0;
                if (rx_s2) begin
                  data_in    <= shift;
                  stop_valid <= 1'b1;
`ifdef UART_RX_PARITY_EN
                  parity_err <= parity_bad;
`endif
                  state      <= ST_IDLE;
                end else begin
                  framing_err <= 1'b1;
                  state       <= ST_WAIT_HIGH;
                end
              end else begin
                os_cnt <= os_cnt + 4'd1;
              end
            end
          end
          // A held-low break parks here so it cannot look like a new start bit.
          ST_WAIT_HIGH: begin
            if (rx_s2) state <= ST_IDLE;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_shifter.sv
// Directed bench for uart_rx_shifter at CLK_DIV=4 (64 clk per bit).
// Parity scenario runs only when UART_RX_PARITY_EN is defined.
module tb_uart_rx_shifter;

  localparam int BIT_CLKS = 64;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx;
  logic       rx_en;
  logic [7:0] data_in;
  logic       stop_valid;
  logic       framing_err;
  logic       busy;
`ifdef UART_RX_PARITY_EN
  logic       parity_err;
  logic       bad_parity;
  int         pe_cnt = 0;
`endif

  int checks   = 0;
  int failures = 0;
  int sv_cnt   = 0;
  int fe_cnt   = 0;
  int busy_run = 0;
  int busy_max = 0;
  logic sv_prev = 1'b0;
  logic fe_prev = 1'b0;
  logic [7:0] exp_q[$];

  uart_rx_shifter #(.CLK_DIV(4), .DATA_BITS(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .rx          (rx),
    .rx_en       (rx_en),
    .data_in     (data_in),
    .stop_valid  (stop_valid),
    .framing_err (framing_err),
    .busy        (busy)
`ifdef UART_RX_PARITY_EN
    ,
    .parity_err  (parity_err)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Scoreboard/monitor on the falling edge, away from the DUT's active edge.
  always @(negedge clk) begin
    if (stop_valid) begin
      sv_cnt++;
      check("sv_one_clk", 32'(sv_prev), 32'd0);
      check("sv_fe_exclusive", 32'(framing_err), 32'd0);
      if (exp_q.size() == 0) check("unexpected_byte", 32'(data_in), 32'hFFFF_FFFF);
      else check("byte", 32'(data_in), 32'(exp_q.pop_front()));
    end
    if (framing_err) begin
      fe_cnt++;
      check("fe_one_clk", 32'(fe_prev), 32'd0);
    end
`ifdef UART_RX_PARITY_EN
    if (parity_err) begin
      pe_cnt++;
      check("pe_with_sv", 32'(stop_valid), 32'd1);
    end
`endif
    sv_prev = stop_valid;
    fe_prev = framing_err;
    busy_run = busy ? busy_run + 1 : 0;
    if (busy_run > busy_max) busy_max = busy_run;
  end

  task automatic bit_time(input logic v);
    rx = v;
    repeat (BIT_CLKS) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    bit_time(1'b0);
    for (int i = 0; i < 8; i++) bit_time(b[i]);
`ifdef UART_RX_PARITY_EN
    bit_time((^b) ^ bad_parity);
`endif
    bit_time(stop_bit);
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int sv0, fe0;
    logic [7:0] partial;
    rst = 1'b0;
    rx = 1'b1;
    rx_en = 1'b1;
`ifdef UART_RX_PARITY_EN
    bad_parity = 1'b0;
`endif
    repeat (4) @(negedge clk);
    check("rst_data_in", 32'(data_in), 32'h00);
    check("rst_stop_valid", 32'(stop_valid), 32'd0);
    check("rst_framing_err", 32'(framing_err), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst = 1'b1;
    idle(10);

    // Good 8N1 frame
    sv0 = sv_cnt; fe0 = fe_cnt;
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 1'b1);
    idle(100);
    check("a5_sv_count", 32'(sv_cnt - sv0), 32'd1);
    check("a5_fe_count", 32'(fe_cnt - fe0), 32'd0);
    check("a5_data_in", 32'(data_in), 32'hA5);
    check("a5_busy_idle", 32'(busy), 32'd0);

    // 20-clk glitch is a false start
    sv0 = sv_cnt; fe0 = fe_cnt;
    busy_max = 0;
    rx = 1'b0;
    repeat (20) @(negedge clk);
    idle(80);
    check("glitch_busy_le40", 32'(busy_max <= 40), 32'd1);
    check("glitch_busy_seen", 32'(busy_max > 0), 32'd1);
    check("glitch_sv", 32'(sv_cnt - sv0), 32'd0);
    check("glitch_fe", 32'(fe_cnt - fe0), 32'd0);
    check("glitch_busy", 32'(busy), 32'd0);

    // Framing error then a 500-clk break
    sv0 = sv_cnt; fe0 = fe_cnt;
    send_frame(8'h3C, 1'b0);
    rx = 1'b0;
    repeat (500) @(negedge clk);
    check("fe_count", 32'(fe_cnt - fe0), 32'd1);
    check("fe_no_sv", 32'(sv_cnt - sv0), 32'd0);
    check("fe_data_kept", 32'(data_in), 32'hA5);
    check("break_busy", 32'(busy), 32'd1);
    idle(20);
    check("break_release_idle", 32'(busy), 32'd0);
    check("break_no_new_fe", 32'(fe_cnt - fe0), 32'd1);

    // Back-to-back frames with no idle gap
    sv0 = sv_cnt;
    exp_q.push_back(8'h00);
    exp_q.push_back(8'hFF);
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    idle(100);
    check("b2b_sv_count", 32'(sv_cnt - sv0), 32'd2);
    check("b2b_data_in", 32'(data_in), 32'hFF);

    // Reset during bit 4 discards the partial byte
    partial = 8'h33;
    bit_time(1'b0);
    for (int i = 0; i < 4; i++) bit_time(partial[i]);
    rx = partial[4];
    repeat (BIT_CLKS / 2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("midrst_data_in", 32'(data_in), 32'h00);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_sv", 32'(stop_valid), 32'd0);
    check("midrst_fe", 32'(framing_err), 32'd0);
    rx = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    idle(100);
    sv0 = sv_cnt;
    exp_q.push_back(8'h5A);
    send_frame(8'h5A, 1'b1);
    idle(100);
    check("post_rst_sv", 32'(sv_cnt - sv0), 32'd1);
    check("post_rst_data", 32'(data_in), 32'h5A);

    // rx_en dropped mid-frame aborts silently
    sv0 = sv_cnt; fe0 = fe_cnt;
    bit_time(1'b0);
    bit_time(1'b1);
    bit_time(1'b0);
    check("en_busy_before", 32'(busy), 32'd1);
    rx_en = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("en_abort_idle", 32'(busy), 32'd0);
    for (int i = 0; i < 7; i++) bit_time(1'b0);
    idle(100);
    rx_en = 1'b1;
    idle(20);
    check("en_abort_sv", 32'(sv_cnt - sv0), 32'd0);
    check("en_abort_fe", 32'(fe_cnt - fe0), 32'd0);
    check("en_abort_data", 32'(data_in), 32'h5A);

`ifdef UART_RX_PARITY_EN
    begin
      int pe0;
      sv0 = sv_cnt; pe0 = pe_cnt;
      bad_parity = 1'b1;
      exp_q.push_back(8'h07);
      send_frame(8'h07, 1'b1);
      bad_parity = 1'b0;
      idle(100);
      check("par_sv", 32'(sv_cnt - sv0), 32'd1);
      check("par_pe", 32'(pe_cnt - pe0), 32'd1);
      check("par_data", 32'(data_in), 32'h07);
    end
`endif

    check("exp_q_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
